// File: rtl/neokeon_pkg.sv
// Shared constants and state type for the Neokeon round sequencer.
package neokeon_pkg;
   localparam int unsigned NUM_ROUNDS  = 16;
   localparam logic [7:0]  RC_ENC_INIT = 8'h80;
   localparam logic [7:0]  RC_DEC_INIT = 8'hD4;
   localparam logic [7:0]  RC_POLY     = 8'h1B;
   localparam int unsigned ROUND_W     = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_KEYPREP,
      ST_ROUND,
      ST_FINAL,
      ST_DONE
   } state_t;
endpackage

// File: rtl/neokeon_rc_step.sv
// One step of the Neokeon round constant: forward (dir = 0) is GF(2^8)
// doubling, inverse (dir = 1) undoes it exactly.
module neokeon_rc_step #(
   parameter logic [7:0] RC_POLY = neokeon_pkg::RC_POLY
) (
   input  logic       dir,
   input  logic [7:0] rc_in,
   output logic [7:0] rc_out
);
   import neokeon_pkg::*;

   always_comb begin
      if (!dir) begin
         rc_out = {rc_in[6:0], 1'b0} ^ (rc_in[7] ? RC_POLY : 8'h00);
      end else begin
         rc_out = rc_in[0] ? (((rc_in ^ RC_POLY) >> 1) | 8'h80) : (rc_in >> 1);
      end
   end
endmodule

// File: rtl/neokeon_round_sequencer.sv
// Control FSM sequencing load, key-prep, rounds and final step of the
// Neokeon datapath, with forward/reverse round-constant generation.
module neokeon_round_sequencer #(
   parameter int unsigned NUM_ROUNDS  = neokeon_pkg::NUM_ROUNDS,
   parameter logic [7:0]  RC_ENC_INIT = neokeon_pkg::RC_ENC_INIT,
   parameter logic [7:0]  RC_DEC_INIT = neokeon_pkg::RC_DEC_INIT,
   parameter logic [7:0]  RC_POLY     = neokeon_pkg::RC_POLY
) (
   input  logic                            inClk,
   input  logic                            inRstN,
   input  logic                            inStart,
   input  logic                            inMode,
   input  logic                            inStall,
   input  logic                            inAck,
   output logic                            outLoad,
   output logic                            outKeyPrep,
   output logic                            outRoundEn,
   output logic                            outFinalEn,
   output logic [7:0]                      outRcIn,
   output logic [7:0]                      outRcOut,
   output logic [neokeon_pkg::ROUND_W-1:0] outRound,
   output logic                            outBusy,
   output logic                            outDone
);
   import neokeon_pkg::*;

   localparam logic [ROUND_W-1:0] LAST_ROUND  = ROUND_W'(NUM_ROUNDS - 1);
   localparam logic [ROUND_W-1:0] FINAL_ROUND = ROUND_W'(NUM_ROUNDS);

   state_t               state, state_nx;
   logic                 mode, mode_nx;
   logic [7:0]           rc, rc_nx, rc_stepped;
   logic [ROUND_W-1:0]   round, round_nx;

   neokeon_rc_step #(.RC_POLY(RC_POLY)) u_rc_step (
      .dir    (mode),
      .rc_in  (rc),
      .rc_out (rc_stepped)
   );

   always_ff @(posedge inClk) begin
      if (!inRstN) begin
         state <= ST_IDLE;
         mode  <= 1'b0;
         rc    <= '0;
         round <= '0;
      end else begin
         state <= state_nx;
         mode  <= mode_nx;
         rc    <= rc_nx;
         round <= round_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      mode_nx    = mode;
      rc_nx      = rc;
      round_nx   = round;
      outLoad    = 1'b0;
      outKeyPrep = 1'b0;
      outRoundEn = 1'b0;
      outFinalEn = 1'b0;
      outRcIn    = '0;
      outRcOut   = '0;
      outRound   = '0;
      outBusy    = 1'b0;
      outDone    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (inStart) begin
               mode_nx  = inMode;
               state_nx = ST_LOAD;
            end
         end
         ST_LOAD: begin
            // Constants are primed here so KEYPREP only has to hold them.
            outLoad  = 1'b1;
            outBusy  = 1'b1;
            rc_nx    = mode ? RC_DEC_INIT : RC_ENC_INIT;
            round_nx = '0;
            state_nx = mode ? ST_KEYPREP : ST_ROUND;
         end
         ST_KEYPREP: begin
            outBusy = 1'b1;
            if (!inStall) begin
               outKeyPrep = 1'b1;
               state_nx   = ST_ROUND;
            end
         end
         ST_ROUND: begin
            outBusy  = 1'b1;
            outRound = round;
            if (mode) outRcOut = rc;
            else      outRcIn  = rc;
            if (!inStall) begin
               outRoundEn = 1'b1;
               round_nx   = round + ROUND_W'(1);
               rc_nx      = rc_stepped;
               if (round == LAST_ROUND) state_nx = ST_FINAL;
            end
         end
         ST_FINAL: begin
            outBusy  = 1'b1;
            outRound = FINAL_ROUND;
            if (mode) outRcOut = rc;
            else      outRcIn  = rc;
            if (!inStall) begin
               outFinalEn = 1'b1;
               state_nx   = ST_DONE;
            end
         end
         ST_DONE: begin
            outDone = 1'b1;
            if (inAck) begin
               if (inStart) begin
                  mode_nx  = inMode;
                  state_nx = ST_LOAD;
               end else begin
                  state_nx = ST_IDLE;
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end
endmodule

// File: tb/tb_neokeon_round_sequencer.sv
// Randomized self-checking bench for neokeon_round_sequencer against a
// step-list model of each operation.
module tb_neokeon_round_sequencer;
   localparam int K_LOAD = 0;
   localparam int K_KEY  = 1;
   localparam int K_RND  = 2;
   localparam int K_FIN  = 3;
   localparam int K_DONE = 4;
   localparam int NR     = 16;

   logic       inClk = 1'b0;
   logic       inRstN, inStart, inMode, inStall, inAck;
   logic       outLoad, outKeyPrep, outRoundEn, outFinalEn, outBusy, outDone;
   logic [7:0] outRcIn, outRcOut;
   logic [4:0] outRound;
   logic [26:0] act;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [7:0]  e [0:NR];

   neokeon_round_sequencer #(
      .NUM_ROUNDS  (16),
      .RC_ENC_INIT (8'h80),
      .RC_DEC_INIT (8'hD4),
      .RC_POLY     (8'h1B)
   ) dut (
      .inClk      (inClk),
      .inRstN     (inRstN),
      .inStart    (inStart),
      .inMode     (inMode),
      .inStall    (inStall),
      .inAck      (inAck),
      .outLoad    (outLoad),
      .outKeyPrep (outKeyPrep),
      .outRoundEn (outRoundEn),
      .outFinalEn (outFinalEn),
      .outRcIn    (outRcIn),
      .outRcOut   (outRcOut),
      .outRound   (outRound),
      .outBusy    (outBusy),
      .outDone    (outDone)
   );

   always #5 inClk = ~inClk;

   assign act = {outLoad, outKeyPrep, outRoundEn, outFinalEn, outRcIn, outRcOut,
                 outRound, outBusy, outDone};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [26:0] pack(input logic l, input logic k, input logic r,
                                        input logic f, input logic [7:0] ri,
                                        input logic [7:0] ro, input logic [4:0] rd,
                                        input logic b, input logic d);
      return {l, k, r, f, ri, ro, rd, b, d};
   endfunction

   // Decrypt constants are the encrypt sequence walked backwards.
   function automatic logic [26:0] expv(input int kind, input int rnd, input logic mode,
                                        input logic stall);
      logic [7:0] rcv;
      case (kind)
         K_LOAD: return pack(1, 0, 0, 0, 8'h00, 8'h00, 5'd0, 1, 0);
         K_KEY:  return pack(0, !stall, 0, 0, 8'h00, 8'h00, 5'd0, 1, 0);
         K_RND: begin
            rcv = mode ? e[NR - rnd] : e[rnd];
            return pack(0, 0, !stall, 0, mode ? 8'h00 : rcv, mode ? rcv : 8'h00,
                        5'(rnd), 1, 0);
         end
         K_FIN: begin
            rcv = mode ? e[0] : e[NR];
            return pack(0, 0, 0, !stall, mode ? 8'h00 : rcv, mode ? rcv : 8'h00,
                        5'(NR), 1, 0);
         end
         default: return pack(0, 0, 0, 0, 8'h00, 8'h00, 5'd0, 0, 1);
      endcase
   endfunction

   task automatic run_op(input logic mode, input int unsigned stall_pct, input int stall_at,
                         input int stall_len, input int abort_at, input bit skip_start,
                         input bit chain, input logic next_mode);
      int kinds[$];
      int rnds[$];
      int idx, cycles, stalls, stall_left;
      logic stall, eff;
      if (!skip_start) begin
         @(negedge inClk);
         inStart = 1'b1; inMode = mode; inAck = 1'b0; inStall = $urandom_range(0, 1);
         #1 check("idle", 32'(act), 32'(pack(0, 0, 0, 0, 8'h00, 8'h00, 5'd0, 0, 0)));
         @(posedge inClk);
      end
      kinds.push_back(K_LOAD); rnds.push_back(0);
      if (mode) begin kinds.push_back(K_KEY); rnds.push_back(0); end
      for (int r = 0; r < NR; r++) begin kinds.push_back(K_RND); rnds.push_back(r); end
      kinds.push_back(K_FIN); rnds.push_back(NR);
      idx = 0; cycles = 0; stalls = 0; stall_left = stall_len;
      while (idx < kinds.size()) begin
         @(negedge inClk);
         cycles++;
         inStart = ($urandom_range(0, 3) == 0);
         inMode  = $urandom_range(0, 1);
         inAck   = $urandom_range(0, 1);
         stall   = 1'b0;
         if (kinds[idx] == K_RND && rnds[idx] == stall_at && stall_left > 0) begin
            stall = 1'b1;
            stall_left--;
         end else if ($urandom_range(0, 99) < stall_pct) begin
            stall = 1'b1;
         end
         inStall = stall;
         if (idx == abort_at) begin
            inRstN = 1'b0;
            @(posedge inClk);
            @(negedge inClk);
            inRstN = 1'b1; inStart = 1'b0; inStall = 1'b0; inAck = 1'b0;
            #1 check("abort_reset", 32'(act), 32'd0);
            return;
         end
         eff = stall && (kinds[idx] != K_LOAD);
         #1 check("step", 32'(act), 32'(expv(kinds[idx], rnds[idx], mode, stall)));
         if (eff) stalls++;
         else     idx++;
         @(posedge inClk);
      end
      @(negedge inClk);
      cycles++;
      inStart = 1'b0; inAck = 1'b0; inStall = $urandom_range(0, 1);
      #1 check("latency", 32'(cycles), 32'(19 + int'(mode) + stalls));
      repeat ($urandom_range(0, 2)) begin
         check("done_hold", 32'(act), 32'(expv(K_DONE, 0, mode, 0)));
         @(posedge inClk);
         @(negedge inClk);
         inStart = $urandom_range(0, 1); inMode = $urandom_range(0, 1);
         #1;
      end
      inAck = 1'b1; inStart = chain; inMode = next_mode;
      #1 check("done_ack", 32'(act), 32'(expv(K_DONE, 0, mode, 0)));
      @(posedge inClk);
      if (!chain) begin
         @(negedge inClk);
         inAck = 1'b0; inStart = 1'b0;
         #1 check("back_idle", 32'(act), 32'd0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bit   chained;
      logic m, nm;
      int   v;
      e[0] = 8'h80;
      for (int i = 1; i <= NR; i++) begin
         v = int'(e[i-1]) * 2;
         if (v >= 256) v = v ^ 'h11B;
         e[i] = 8'(v);
      end
      inRstN = 1'b0; inStart = 1'b1; inMode = 1'b1; inStall = 1'b0; inAck = 1'b0;
      repeat (2) @(posedge inClk);
      @(negedge inClk);
      #1 check("reset", 32'(act), 32'd0);
      inRstN = 1'b1; inStart = 1'b0;

      run_op(1'b0, 0, -1, 0, -1, 0, 0, 1'b0);
      run_op(1'b1, 0, -1, 0, -1, 0, 0, 1'b0);
      run_op(1'b0, 0, 5, 3, -1, 0, 0, 1'b0);
      run_op(1'b0, 0, -1, 0, 10, 0, 0, 1'b0);
      run_op(1'b1, 0, -1, 0, 8, 0, 0, 1'b0);
      run_op(1'b0, 0, -1, 0, -1, 0, 1, 1'b1);
      run_op(1'b1, 0, -1, 0, -1, 1, 0, 1'b0);

      chained = 0; m = 1'b0;
      repeat (12) begin
         nm = $urandom_range(0, 1);
         run_op(m, $urandom_range(0, 40), -1, 0, -1, chained, 1'b1, nm);
         m = nm; chained = 1;
      end
      run_op(m, 20, -1, 0, -1, 1, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
